// File: rtl/pulse_meas_pkg.sv
// Shared definitions for the pulse-measurement path: FSM encoding and the
// default count width used by the meter and the SPI readout stage.
package pulse_meas_pkg;

  localparam int unsigned CNT_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_MEASURE,
    ST_DONE
  } meas_state_e;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous pin plus a registered copy
// for rising-edge detection in the clk domain.
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic rise
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic dly_q,  dly_d;

  always_comb begin
    meta_d = din;
    sync_d = meta_q;
    dly_d  = sync_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      dly_q  <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      dly_q  <= dly_d;
    end
  end

  assign sync = sync_q;
  assign rise = sync_q & ~dly_q;

endmodule

// File: rtl/equ_prec_freq_meter.sv
// Equal-precision frequency / duty counter: gate opens and closes on signal
// rising edges, results are buffered with a one-cycle data_valid strobe.
module equ_prec_freq_meter
  import pulse_meas_pkg::*;
#(
  parameter logic [31:0] GATE_CYCLES    = 32'd50_000_000,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd100_000_000,
  parameter int unsigned CNT_WIDTH      = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rest,
  input  logic                 enable,
  input  logic                 sig_in,
  output logic [CNT_WIDTH-1:0] fs_cnt_buff,
  output logic [CNT_WIDTH-1:0] fx_cnt_buff,
  output logic [CNT_WIDTH-1:0] high_cnt_buff,
  output logic                 data_valid,
  output logic                 timeout
);

  typedef logic [CNT_WIDTH-1:0] cnt_t;

  localparam logic [31:0] WAIT_LIMIT = TIMEOUT_CYCLES - 32'd1;

  function automatic cnt_t sat_inc(input cnt_t v);
    return (v == '1) ? v : v + cnt_t'(1);
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  logic sync, rise;

  sync_edge_det u_sync (
    .clk  (clk),
    .rst  (rest),
    .din  (sig_in),
    .sync (sync),
    .rise (rise)
  );

  meas_state_e state_q, state_d;
  cnt_t        fs_q, fs_d, fx_q, fx_d, high_q, high_d;
  logic [31:0] gate_q, gate_d, wait_q, wait_d;
  cnt_t        fs_buf_q, fs_buf_d, fx_buf_q, fx_buf_d, high_buf_q, high_buf_d;
  logic        data_valid_q, data_valid_d;
  logic        timeout_q, timeout_d;
  logic        wait_expired;

  // Buffers and data_valid are loaded on the closing edge itself, so they
  // change on the same clock edge that puts the FSM into DONE.
  always_comb begin
    state_d      = state_q;
    fs_d         = fs_q;
    fx_d         = fx_q;
    high_d       = high_q;
    gate_d       = gate_q;
    wait_d       = wait_q;
    fs_buf_d     = fs_buf_q;
    fx_buf_d     = fx_buf_q;
    high_buf_d   = high_buf_q;
    data_valid_d = 1'b0;
    timeout_d    = timeout_q;
    wait_expired = (wait_q >= WAIT_LIMIT) && !rise;

    case (state_q)
      ST_IDLE: begin
        wait_d = '0;
        if (enable) state_d = ST_ARM;
      end
      ST_ARM: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (rise) begin
          fs_d    = cnt_t'(1);
          fx_d    = '0;
          high_d  = cnt_t'(sync);
          gate_d  = 32'd1;
          wait_d  = '0;
          state_d = ST_MEASURE;
        end else if (wait_expired) begin
          fs_buf_d     = '0;
          fx_buf_d     = '0;
          high_buf_d   = '0;
          timeout_d    = 1'b1;
          data_valid_d = 1'b1;
          wait_d       = '0;
        end else begin
          wait_d = sat_inc32(wait_q);
        end
      end
      ST_MEASURE: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (rise && (gate_q >= GATE_CYCLES)) begin
          fx_d         = sat_inc(fx_q);
          fs_buf_d     = fs_q;
          fx_buf_d     = sat_inc(fx_q);
          high_buf_d   = high_q;
          timeout_d    = 1'b0;
          data_valid_d = 1'b1;
          state_d      = ST_DONE;
        end else if (wait_expired) begin
          fs_buf_d     = '0;
          fx_buf_d     = '0;
          high_buf_d   = '0;
          timeout_d    = 1'b1;
          data_valid_d = 1'b1;
          wait_d       = '0;
          state_d      = ST_ARM;
        end else begin
          fs_d   = sat_inc(fs_q);
          gate_d = sat_inc32(gate_q);
          if (sync) high_d = sat_inc(high_q);
          if (rise) begin
            fx_d   = sat_inc(fx_q);
            wait_d = '0;
          end else begin
            wait_d = sat_inc32(wait_q);
          end
        end
      end
      ST_DONE: begin
        wait_d  = '0;
        state_d = enable ? ST_ARM : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      state_q      <= ST_IDLE;
      fs_q         <= '0;
      fx_q         <= '0;
      high_q       <= '0;
      gate_q       <= '0;
      wait_q       <= '0;
      fs_buf_q     <= '0;
      fx_buf_q     <= '0;
      high_buf_q   <= '0;
      data_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      fs_q         <= fs_d;
      fx_q         <= fx_d;
      high_q       <= high_d;
      gate_q       <= gate_d;
      wait_q       <= wait_d;
      fs_buf_q     <= fs_buf_d;
      fx_buf_q     <= fx_buf_d;
      high_buf_q   <= high_buf_d;
      data_valid_q <= data_valid_d;
      timeout_q    <= timeout_d;
    end
  end

  assign fs_cnt_buff   = fs_buf_q;
  assign fx_cnt_buff   = fx_buf_q;
  assign high_cnt_buff = high_buf_q;
  assign data_valid    = data_valid_q;
  assign timeout       = timeout_q;

endmodule
